// File: rtl/dtpu_stim_pkg.sv
// Shared types and constants for the dtpu_core stimulus/checker harness.
package dtpu_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } stim_state_t;

  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_INC   = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;

  // Right-shifting Galois masks: x^64+x^63+x^61+x^60+1 and x^16+x^14+x^13+x^11+1.
  localparam logic [63:0] LFSR64_TAPS = 64'hD800_0000_0000_0000;
  localparam logic [15:0] LFSR16_TAPS = 16'hB400;
  localparam logic [15:0] LFSR16_SEED = 16'hACE1;

  function automatic logic [63:0] rotl64(input logic [63:0] v, input logic [5:0] n);
    logic [127:0] d;
    d = {v, v} << n;
    return d[127:64];
  endfunction

endpackage

// File: rtl/dtpu_pattern_gen.sv
// 64-bit data-pattern generator (constant / increment / Galois LFSR) with
// replication of the current word onto the input-stream width.
module dtpu_pattern_gen
  import dtpu_stim_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [1:0]            mode,
  input  logic [63:0]           seed,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [63:0] value;
  logic [1:0]  mode_q;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      value  <= '0;
      mode_q <= MODE_CONST;
    end else if (enable) begin
      if (load) begin
        mode_q <= mode;
        // An all-zero LFSR state would lock up, so it starts from 1 instead.
        value  <= (mode == MODE_LFSR && seed == '0) ? 64'd1 : seed;
      end else if (advance) begin
        case (mode_q)
          MODE_INC:  value <= value + 64'd1;
          MODE_LFSR: value <= (value >> 1) ^ (value[0] ? LFSR64_TAPS : 64'd0);
          default:   value <= value;
        endcase
      end
    end
  end

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_rep
    assign dout[i] = value[i % 64];
  end

endmodule

// File: rtl/dtpu_stim_gen.sv
// Stimulus/checker harness for dtpu_core: setup -> start -> stream -> check.
// Optional macro DTPU_STIM_BACKPRESSURE_EN adds pseudo-random output-FIFO full.
module dtpu_stim_gen
  import dtpu_stim_pkg::*;
#(
  parameter int DATA_WIDTH_FIFO_IN  = 64,
  parameter int DATA_WIDTH_FIFO_OUT = 64,
  parameter int MAX_WORDS           = 1024,
  parameter int SETUP_CYCLES        = 7,
  parameter int TIMEOUT_CYCLES      = 4096,
  localparam int LEN_W              = $clog2(MAX_WORDS + 1)
) (
  input  logic                           clk,
  input  logic                           areset,
  input  logic                           enable,
  input  logic                           go,
  input  logic [1:0]                     mode,
  input  logic [63:0]                    seed,
  input  logic [LEN_W-1:0]               len,
  input  logic [LEN_W-1:0]               exp_count,
  input  logic [63:0]                    exp_sig,
  output logic                           infifo_is_empty,
  output logic [DATA_WIDTH_FIFO_IN-1:0]  infifo_dout,
  input  logic                           infifo_read,
  output logic                           outfifo_is_full,
  input  logic [DATA_WIDTH_FIFO_OUT-1:0] outfifo_din,
  input  logic                           outfifo_write,
  output logic                           cs_start,
  output logic                           cs_continue,
  input  logic                           cs_done,
  input  logic                           cs_idle,
  input  logic                           cs_ready,
  output logic                           busy,
  output logic                           pass,
  output logic                           fail,
  output logic                           timeout,
  output logic                           proto_err,
  output logic [LEN_W-1:0]               out_count,
  output logic [63:0]                    signature,
  output logic [2:0]                     state_dbg
);

  localparam int SC_W = $clog2(SETUP_CYCLES + 2);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  stim_state_t      state;
  logic [LEN_W-1:0] len_q, sent, len_clamped;
  logic [SC_W-1:0]  setup_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic [63:0]      din_ext;
  logic             active, consume, accept, rd_err, wr_err, results_ok;

  // Handshake: a word moves on the input side when infifo_read && !infifo_is_empty
  // and on the output side when outfifo_write && !outfifo_is_full, both only with
  // enable=1; a strobe against empty/full is a protocol error and moves nothing.
  assign active      = (state == ST_SETUP) || (state == ST_START) || (state == ST_RUN);
  assign infifo_is_empty = (state != ST_RUN) || (sent == len_q);
  assign consume     = enable && active && infifo_read && !infifo_is_empty;
  assign rd_err      = enable && active && infifo_read && infifo_is_empty;
  assign accept      = enable && active && outfifo_write && !outfifo_is_full;
  assign wr_err      = enable && active && outfifo_write && outfifo_is_full;
  assign len_clamped = (len > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : len;
  assign results_ok  = (out_count == exp_count) && (signature == exp_sig) && !proto_err;
  assign busy        = (state != ST_IDLE);
  assign state_dbg   = state;

  for (genvar i = 0; i < 64; i++) begin : g_ext
    if (i < DATA_WIDTH_FIFO_OUT) begin : g_bit
      assign din_ext[i] = outfifo_din[i];
    end else begin : g_zero
      assign din_ext[i] = 1'b0;
    end
  end

  dtpu_pattern_gen #(.DATA_WIDTH(DATA_WIDTH_FIFO_IN)) u_gen (
    .clk     (clk),
    .areset  (areset),
    .enable  (enable),
    .load    ((state == ST_IDLE) && go),
    .mode    (mode),
    .seed    (seed),
    .advance (consume),
    .dout    (infifo_dout)
  );

`ifdef DTPU_STIM_BACKPRESSURE_EN
  logic [15:0] bp_lfsr;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) bp_lfsr <= LFSR16_SEED;
    else if (enable) bp_lfsr <= (bp_lfsr >> 1) ^ (bp_lfsr[0] ? LFSR16_TAPS : 16'd0);
  end

  assign outfifo_is_full = (state == ST_RUN) && bp_lfsr[0];
`else
  assign outfifo_is_full = 1'b0;
`endif

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      sent        <= '0;
      setup_cnt   <= '0;
      wd_cnt      <= '0;
      cs_start    <= 1'b0;
      cs_continue <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      proto_err   <= 1'b0;
      out_count   <= '0;
      signature   <= '0;
    end else if (enable) begin
      if (accept) begin
        signature <= rotl64(signature, 6'd1) ^ din_ext;
        if (out_count != '1) out_count <= out_count + LEN_W'(1);
      end
      if (rd_err || wr_err) proto_err <= 1'b1;
      if (consume) sent <= sent + LEN_W'(1);
      if (active) wd_cnt <= wd_cnt + WD_W'(1);

      case (state)
        ST_IDLE: begin
          if (go) begin
            state     <= ST_SETUP;
            len_q     <= len_clamped;
            sent      <= '0;
            setup_cnt <= '0;
            wd_cnt    <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            proto_err <= 1'b0;
            out_count <= '0;
            signature <= '0;
          end
        end
        ST_SETUP: begin
          if (setup_cnt != SC_W'(SETUP_CYCLES)) begin
            setup_cnt <= setup_cnt + SC_W'(1);
          end else if (cs_idle) begin
            state    <= ST_START;
            cs_start <= 1'b1;
          end
        end
        ST_START: begin
          if (cs_ready) begin
            state    <= ST_RUN;
            cs_start <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cs_done) begin
            state       <= ST_CHECK;
            cs_continue <= 1'b1;
          end
        end
        ST_CHECK: begin
          cs_continue <= 1'b0;
          pass        <= results_ok;
          fail        <= !results_ok;
          state       <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase

      // Watchdog overrides any normal transition in the same cycle.
      if (active && wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
        state       <= ST_DONE;
        timeout     <= 1'b1;
        fail        <= 1'b1;
        pass        <= 1'b0;
        cs_start    <= 1'b0;
        cs_continue <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dtpu_stim_gen.sv
// Directed + randomized bench for dtpu_stim_gen with a word-level reference model
// of the pattern generator, signature fold and run verdict.
module tb_dtpu_stim_gen;

  localparam int DIN_W          = 64;
  localparam int DOUT_W         = 64;
  localparam int MAX_WORDS      = 1024;
  localparam int LEN_W          = $clog2(MAX_WORDS + 1);
  localparam int SETUP_CYCLES   = 7;
  localparam int TIMEOUT_CYCLES = 4096;

  logic              clk = 1'b0;
  logic              areset = 1'b0;
  logic              enable = 1'b1;
  logic              go = 1'b0;
  logic [1:0]        mode = '0;
  logic [63:0]       seed = '0;
  logic [LEN_W-1:0]  len = '0;
  logic [LEN_W-1:0]  exp_count = '0;
  logic [63:0]       exp_sig = '0;
  logic              infifo_is_empty;
  logic [DIN_W-1:0]  infifo_dout;
  logic              infifo_read = 1'b0;
  logic              outfifo_is_full;
  logic [DOUT_W-1:0] outfifo_din = '0;
  logic              outfifo_write = 1'b0;
  logic              cs_start, cs_continue;
  logic              cs_done = 1'b0;
  logic              cs_idle = 1'b1;
  logic              cs_ready = 1'b0;
  logic              busy, pass, fail, timeout, proto_err;
  logic [LEN_W-1:0]  out_count;
  logic [63:0]       signature;
  logic [2:0]        state_dbg;

  // Clock/reset block
  always #5 clk = ~clk;

  dtpu_stim_gen #(
    .DATA_WIDTH_FIFO_IN  (DIN_W),
    .DATA_WIDTH_FIFO_OUT (DOUT_W),
    .MAX_WORDS           (MAX_WORDS),
    .SETUP_CYCLES        (SETUP_CYCLES),
    .TIMEOUT_CYCLES      (TIMEOUT_CYCLES)
  ) dut (
    .clk             (clk),
    .areset          (areset),
    .enable          (enable),
    .go              (go),
    .mode            (mode),
    .seed            (seed),
    .len             (len),
    .exp_count       (exp_count),
    .exp_sig         (exp_sig),
    .infifo_is_empty (infifo_is_empty),
    .infifo_dout     (infifo_dout),
    .infifo_read     (infifo_read),
    .outfifo_is_full (outfifo_is_full),
    .outfifo_din     (outfifo_din),
    .outfifo_write   (outfifo_write),
    .cs_start        (cs_start),
    .cs_continue     (cs_continue),
    .cs_done         (cs_done),
    .cs_idle         (cs_idle),
    .cs_ready        (cs_ready),
    .busy            (busy),
    .pass            (pass),
    .fail            (fail),
    .timeout         (timeout),
    .proto_err       (proto_err),
    .out_count       (out_count),
    .signature       (signature),
    .state_dbg       (state_dbg)
  );

  // Scoreboard state
  int          checks = 0;
  int          errors = 0;
  string       cur_run = "reset";
  logic [63:0] exp_q[$];
  logic [63:0] seen[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%h expected=%h", cur_run, tag, obs, exp);
    end
  endtask

  // Reference generator step from the polynomial x^64+x^63+x^61+x^60+1.
  function automatic logic [63:0] model_lfsr(input logic [63:0] v);
    logic [63:0] poly;
    int          taps[4];
    poly = '0;
    taps = '{64, 63, 61, 60};
    foreach (taps[i]) poly[taps[i]-1] = 1'b1;
    return v[0] ? ((v >> 1) ^ poly) : (v >> 1);
  endfunction

  function automatic logic [63:0] model_fold(input logic [63:0] sig, input logic [63:0] w);
    return {sig[62:0], sig[63]} ^ w;
  endfunction

  task automatic check_reset_values();
    check("rst_empty", 64'(infifo_is_empty), 64'd1);
    check("rst_dout", 64'(infifo_dout), 64'd0);
    check("rst_full", 64'(outfifo_is_full), 64'd0);
    check("rst_start", 64'(cs_start), 64'd0);
    check("rst_cont", 64'(cs_continue), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_fail", 64'(fail), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_proto", 64'(proto_err), 64'd0);
    check("rst_count", 64'(out_count), 64'd0);
    check("rst_sig", signature, 64'd0);
  endtask

  // Driver: one full run with a core model that reads n_reads times and echoes
  // every consumed word. freeze_at: cycle with enable=0; reset_after: words
  // consumed before areset is pulsed (-1 = never).
  task automatic do_run(input string name, input logic [1:0] m, input logic [63:0] s,
                        input int l, input int n_reads, input bit bad_sig,
                        input int freeze_at, input int reset_after);
    int          len_eff, n_words, cyc, sent_m, rd_cnt, cnt_m;
    logic [63:0] v, w, sig_pred, sig_m;
    logic [63:0] pend[$];
    bit          perr_m, done, pass_m;
    cur_run = name;
    len_eff = (l > MAX_WORDS) ? MAX_WORDS : l;
    n_words = (n_reads < len_eff) ? n_reads : len_eff;
    exp_q.delete();
    seen.delete();
    v = (m == 2'd2 && s == 64'd0) ? 64'd1 : s;
    sig_pred = '0;
    for (int i = 0; i < len_eff; i++) begin
      w = (m == 2'd1) ? s + 64'(i) : (m == 2'd2) ? v : s;
      exp_q.push_back(w);
      if (i < n_words) sig_pred = model_fold(sig_pred, w);
      v = model_lfsr(v);
    end

    @(negedge clk);
    mode = m; seed = s; len = LEN_W'(l);
    exp_count = LEN_W'(n_words);
    exp_sig = sig_pred ^ {63'd0, bad_sig};
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("busy", 64'(busy), 64'd1);
    cyc = 0;
    while (!cs_start && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("start_latency", 64'(cyc), 64'(SETUP_CYCLES + 1));
    cs_ready = 1'b1;
    @(negedge clk);
    cs_ready = 1'b0;
    check("start_drop", 64'(cs_start), 64'd0);

    rd_cnt = 0; sent_m = 0; cnt_m = 0; sig_m = '0; perr_m = 1'b0; done = 1'b0; cyc = 0;
    while (!done && cyc < 3000) begin
      infifo_read = 1'b0; outfifo_write = 1'b0; cs_done = 1'b0; enable = 1'b1;
      if (reset_after >= 0 && sent_m == reset_after) begin
        areset = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        check("rst_hold_cont", 64'(cs_continue), 64'd0);
        areset = 1'b1;
        return;
      end
      if (cyc == freeze_at) begin
        enable = 1'b0; infifo_read = 1'b1; outfifo_write = 1'b1;
        outfifo_din = {$urandom, $urandom};
        if (exp_q.size() > 0) check("freeze_dout", 64'(infifo_dout), exp_q[0]);
      end else begin
        check("empty", 64'(infifo_is_empty), 64'(sent_m == len_eff));
        if (rd_cnt < n_reads) begin
          infifo_read = 1'b1;
          rd_cnt++;
          if (!infifo_is_empty && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("dout", 64'(infifo_dout), w);
            seen.push_back(64'(infifo_dout));
            pend.push_back(64'(infifo_dout));
            sent_m++;
          end else begin
            perr_m = 1'b1;
          end
        end
        if (pend.size() > 0 && !outfifo_is_full) begin
          outfifo_write = 1'b1;
          outfifo_din = DOUT_W'(pend.pop_front());
          sig_m = model_fold(sig_m, 64'(outfifo_din));
          cnt_m++;
        end
        if (rd_cnt == n_reads && pend.size() == 0) begin
          cs_done = 1'b1;
          done = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    infifo_read = 1'b0; outfifo_write = 1'b0; cs_done = 1'b0; enable = 1'b1;
    check("run_bounded", 64'(done), 64'd1);
    check("continue", 64'(cs_continue), 64'd1);
    @(negedge clk);
    pass_m = (cnt_m == n_words) && (sig_m == exp_sig) && !perr_m;
    check("cont_drop", 64'(cs_continue), 64'd0);
    check("pass", 64'(pass), 64'(pass_m));
    check("fail", 64'(fail), 64'(!pass_m));
    check("timeout", 64'(timeout), 64'd0);
    check("proto_err", 64'(proto_err), 64'(perr_m));
    check("out_count", 64'(out_count), 64'(cnt_m));
    check("signature", signature, sig_m);
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("held_pass", 64'(pass), 64'(pass_m));
    check("sb_left", 64'(exp_q.size()), 64'(len_eff - n_words));
  endtask

  task automatic do_timeout_run();
    int cyc;
    bit saw_cont;
    cur_run = "timeout";
    @(negedge clk);
    mode = 2'd1; seed = 64'd5; len = LEN_W'(4); exp_count = '0; exp_sig = '0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    cyc = 0;
    saw_cont = 1'b0;
    while (!timeout && cyc < TIMEOUT_CYCLES + 50) begin
      @(negedge clk);
      cyc++;
      if (cs_continue) saw_cont = 1'b1;
    end
    check("to_cycles", 64'(cyc), 64'(TIMEOUT_CYCLES));
    check("to_flag", 64'(timeout), 64'd1);
    check("to_fail", 64'(fail), 64'd1);
    check("to_pass", 64'(pass), 64'd0);
    check("to_start", 64'(cs_start), 64'd0);
    check("to_no_cont", 64'(saw_cont), 64'd0);
    @(negedge clk);
    check("to_idle", 64'(busy), 64'd0);
    check("to_held", 64'(timeout), 64'd1);
  endtask

  initial begin
    int l;
    repeat (3) @(negedge clk);
    check_reset_values();
    areset = 1'b1;
    repeat (2) @(negedge clk);

    do_run("const_cafe", 2'd0, 64'hCAFECAFECAFECAFE, 4, 4, 1'b0, -1, -1);
    do_run("inc_overread", 2'd1, 64'd0, 3, 4, 1'b0, -1, -1);
    check("inc_w0", seen[0], 64'd0);
    check("inc_w2", seen[2], 64'd2);
    do_run("lfsr_zero_seed", 2'd2, 64'd0, 2, 2, 1'b0, -1, -1);
    check("lfsr_w0", seen[0], 64'd1);
    check("lfsr_w1", seen[1], 64'hD800_0000_0000_0000);
    do_timeout_run();
    do_run("bad_sig", 2'($urandom_range(0, 3)), {$urandom, $urandom}, 5, 5, 1'b1, -1, -1);
    do_run("reset_mid", 2'd1, {$urandom, $urandom}, 6, 6, 1'b0, -1, 2);
    do_run("after_reset", 2'd2, {$urandom, $urandom}, 6, 6, 1'b0, -1, -1);
    do_run("len_zero", 2'd1, 64'd9, 0, 0, 1'b0, -1, -1);
    do_run("freeze", 2'd1, {$urandom, $urandom}, 5, 5, 1'b0, 2, -1);
    do_run("mode3", 2'd3, {$urandom, $urandom}, 3, 3, 1'b0, -1, -1);
    do_run("clamp", 2'd2, {$urandom, $urandom}, MAX_WORDS + 5, MAX_WORDS, 1'b0, -1, -1);
    for (int r = 0; r < 4; r++) begin
      l = $urandom_range(1, 12);
      do_run("random", 2'($urandom_range(0, 3)), {$urandom, $urandom}, l, l, 1'b0, -1, -1);
    end

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
